// File: rtl/hdr_payload_splitter.sv
// Avalon-ST header/payload splitter: the first L beats of each packet go to a header FIFO,
// and the remaining beats go to an ID-tagged payload FIFO. Drop and short-packet counters are kept.
module hps_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      cnt_q;
    logic             do_push, do_pop;

    // Full is taken from the registered count, so a push into a full FIFO is blocked
    // even when the same cycle also pops.
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem_q[rptr_q];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= (wptr_q == AW'(DEPTH-1)) ? '0 : wptr_q + AW'(1);
            if (do_pop)  rptr_q <= (rptr_q == AW'(DEPTH-1)) ? '0 : rptr_q + AW'(1);
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= din_i;
    end
endmodule

module hdr_payload_splitter #(
    parameter int DATA_WIDTH       = 64,
    parameter int MAX_HEADER_BEATS = 10,
    parameter int HDR_FIFO_DEPTH   = 64,
    parameter int PAY_FIFO_DEPTH   = 64,
    parameter int ID_WIDTH         = 32,
    parameter int ID_MSB           = DATA_WIDTH-2,
    localparam int EW = $clog2(DATA_WIDTH/8),
    localparam int CW = $clog2(MAX_HEADER_BEATS+1)
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [CW-1:0]         cfg_hdr_beats_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic                  in_sop_i,
    input  logic                  in_eop_i,
    input  logic                  in_error_i,
    input  logic [EW-1:0]         in_empty_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    output logic                  hdr_valid_o,
    input  logic                  hdr_ready_i,
    output logic                  hdr_sop_o,
    output logic                  hdr_eop_o,
    output logic                  hdr_error_o,
    output logic [EW-1:0]         hdr_empty_o,
    output logic [DATA_WIDTH-1:0] hdr_data_o,
    output logic                  pay_valid_o,
    input  logic                  pay_ready_i,
    output logic                  pay_sop_o,
    output logic                  pay_eop_o,
    output logic                  pay_error_o,
    output logic [EW-1:0]         pay_empty_o,
    output logic [DATA_WIDTH-1:0] pay_data_o,
    output logic [ID_WIDTH-1:0]   pay_id_o,
    output logic [ID_WIDTH-1:0]   o_id_o,
    output logic [31:0]           stat_pkts_o,
    output logic [31:0]           stat_short_o,
    output logic [31:0]           stat_drop_o
);
    localparam int HW = DATA_WIDTH + EW + 3;
    localparam int PW = HW + ID_WIDTH;

    typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d, len_q, len_d, eff_len;
    logic [ID_WIDTH-1:0] id_q, id_d, o_id_q;
    logic                pay_first_q, pay_first_d;
    logic [31:0]         pkts_q, pkts_d, short_q, short_d, drop_q, drop_d;
    logic                accept, hdr_push, pay_push, h_sop, h_eop;
    logic [EW-1:0]       h_empty;
    logic                hdr_full, pay_full, hdr_fifo_empty, pay_fifo_empty;
    logic [HW-1:0]       hdr_dout;
    logic [PW-1:0]       pay_dout;

    always_comb begin
        eff_len = cfg_hdr_beats_i;
        if (cfg_hdr_beats_i == '0)                         eff_len = CW'(1);
        else if (cfg_hdr_beats_i > CW'(MAX_HEADER_BEATS))  eff_len = CW'(MAX_HEADER_BEATS);
    end

    assign in_ready_o = (state_q == PAY) ? !pay_full : !hdr_full;
    assign accept     = in_valid_i && in_ready_o;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        id_d        = id_q;
        pay_first_d = pay_first_q;
        pkts_d      = pkts_q;
        short_d     = short_q;
        drop_d      = drop_q;
        hdr_push    = 1'b0;
        pay_push    = 1'b0;
        h_sop       = 1'b0;
        h_eop       = in_eop_i;
        h_empty     = in_empty_i;
        unique case (state_q)
            IDLE: if (accept) begin
                if (!in_sop_i) begin
                    drop_d = drop_q + 32'd1;
                end else begin
                    hdr_push = 1'b1;
                    h_sop    = 1'b1;
                    id_d     = in_data_i[ID_MSB -: ID_WIDTH];
                    cnt_d    = CW'(1);
                    len_d    = eff_len;
                    if (in_eop_i) begin
                        pkts_d  = pkts_q + 32'd1;
                        short_d = short_q + 32'd1;
                    end else if (eff_len == CW'(1)) begin
                        h_eop       = 1'b1;
                        h_empty     = '0;
                        pay_first_d = 1'b1;
                        state_d     = PAY;
                    end else begin
                        state_d = HDR;
                    end
                end
            end
            HDR: if (accept) begin
                hdr_push = 1'b1;
                cnt_d    = cnt_q + CW'(1);
                if (in_eop_i) begin
                    pkts_d  = pkts_q + 32'd1;
                    short_d = short_q + 32'd1;
                    state_d = IDLE;
                end else if (cnt_q + CW'(1) == len_q) begin
                    h_eop       = 1'b1;
                    h_empty     = '0;
                    pay_first_d = 1'b1;
                    state_d     = PAY;
                end
            end
            PAY: if (accept) begin
                pay_push    = 1'b1;
                pay_first_d = 1'b0;
                if (in_eop_i) begin
                    pkts_d  = pkts_q + 32'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            len_q       <= '0;
            id_q        <= '0;
            pay_first_q <= 1'b0;
            pkts_q      <= '0;
            short_q     <= '0;
            drop_q      <= '0;
            o_id_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            id_q        <= id_d;
            pay_first_q <= pay_first_d;
            pkts_q      <= pkts_d;
            short_q     <= short_d;
            drop_q      <= drop_d;
            if (pay_valid_o && pay_ready_i && pay_sop_o) o_id_q <= pay_id_o;
        end
    end

    hps_fifo #(.WIDTH(HW), .DEPTH(HDR_FIFO_DEPTH)) u_hdr_fifo (
        .clk_i(clk_i), .reset_i(reset_i), .push_i(hdr_push),
        .din_i({in_error_i, h_empty, h_eop, h_sop, in_data_i}),
        .pop_i(hdr_ready_i), .dout_o(hdr_dout), .full_o(hdr_full), .empty_o(hdr_fifo_empty)
    );

    hps_fifo #(.WIDTH(PW), .DEPTH(PAY_FIFO_DEPTH)) u_pay_fifo (
        .clk_i(clk_i), .reset_i(reset_i), .push_i(pay_push),
        .din_i({id_q, in_error_i, in_empty_i, in_eop_i, pay_first_q, in_data_i}),
        .pop_i(pay_ready_i), .dout_o(pay_dout), .full_o(pay_full), .empty_o(pay_fifo_empty)
    );

    assign hdr_valid_o = !hdr_fifo_empty;
    assign pay_valid_o = !pay_fifo_empty;
    assign {hdr_error_o, hdr_empty_o, hdr_eop_o, hdr_sop_o, hdr_data_o} = hdr_dout;
    assign {pay_id_o, pay_error_o, pay_empty_o, pay_eop_o, pay_sop_o, pay_data_o} = pay_dout;
    assign o_id_o       = o_id_q;
    assign stat_pkts_o  = pkts_q;
    assign stat_short_o = short_q;
    assign stat_drop_o  = drop_q;
endmodule

// File: tb/tb_hdr_payload_splitter.sv
// Bench for hdr_payload_splitter: directed and random packets are compared each cycle
// against a queue-based model of the header/payload split.
module tb_hdr_payload_splitter;
    localparam int DW = 64, MAXH = 10, HD = 4, PD = 8, IDW = 32, IDM = DW-2;
    localparam int EW = $clog2(DW/8), CW = $clog2(MAXH+1);

    typedef struct {
        logic [DW-1:0]  d;
        logic           sop, eop, err;
        logic [EW-1:0]  e;
        logic [IDW-1:0] id;
        logic [CW-1:0]  cfg;
    } beat_t;

    logic clk = 1'b0, reset = 1'b1;
    logic [CW-1:0] cfg = '0;
    logic in_valid = 0, in_ready, in_sop = 0, in_eop = 0, in_error = 0;
    logic [EW-1:0] in_empty = '0;
    logic [DW-1:0] in_data = '0;
    logic hdr_valid, hdr_ready = 1, hdr_sop, hdr_eop, hdr_error;
    logic [EW-1:0] hdr_empty;
    logic [DW-1:0] hdr_data;
    logic pay_valid, pay_ready = 1, pay_sop, pay_eop, pay_error;
    logic [EW-1:0] pay_empty;
    logic [DW-1:0] pay_data;
    logic [IDW-1:0] pay_id, o_id;
    logic [31:0] stat_pkts, stat_short, stat_drop;

    always #5 clk = ~clk;

    hdr_payload_splitter #(.DATA_WIDTH(DW), .MAX_HEADER_BEATS(MAXH), .HDR_FIFO_DEPTH(HD),
                           .PAY_FIFO_DEPTH(PD), .ID_WIDTH(IDW), .ID_MSB(IDM)) dut (
        .clk_i(clk), .reset_i(reset), .cfg_hdr_beats_i(cfg),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_sop_i(in_sop), .in_eop_i(in_eop),
        .in_error_i(in_error), .in_empty_i(in_empty), .in_data_i(in_data),
        .hdr_valid_o(hdr_valid), .hdr_ready_i(hdr_ready), .hdr_sop_o(hdr_sop), .hdr_eop_o(hdr_eop),
        .hdr_error_o(hdr_error), .hdr_empty_o(hdr_empty), .hdr_data_o(hdr_data),
        .pay_valid_o(pay_valid), .pay_ready_i(pay_ready), .pay_sop_o(pay_sop), .pay_eop_o(pay_eop),
        .pay_error_o(pay_error), .pay_empty_o(pay_empty), .pay_data_o(pay_data), .pay_id_o(pay_id),
        .o_id_o(o_id), .stat_pkts_o(stat_pkts), .stat_short_o(stat_short), .stat_drop_o(stat_drop)
    );

    // Reference model: pending input beats, expected FIFO contents, packet position.
    beat_t inq[$], hq[$], pq[$];
    bit in_pkt;
    int idx, plen, rmode;
    logic [IDW-1:0] cur_id, m_oid;
    int unsigned m_pkts, m_short, m_drop;
    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_accept(input beat_t b);
        beat_t o;
        o = b;
        if (!in_pkt) begin
            if (!b.sop) begin m_drop++; return; end
            in_pkt = 1; idx = 0;
            plen   = (b.cfg == 0) ? 1 : (int'(b.cfg) > MAXH) ? MAXH : int'(b.cfg);
            cur_id = b.d[IDM -: IDW];
        end
        o.id = cur_id;
        if (idx < plen) begin
            o.sop = (idx == 0);
            if (b.eop) begin in_pkt = 0; m_pkts++; m_short++; end
            else if (idx == plen-1) begin o.eop = 1; o.e = '0; end
            hq.push_back(o);
        end else begin
            o.sop = (idx == plen);
            if (b.eop) begin in_pkt = 0; m_pkts++; end
            pq.push_back(o);
        end
        idx++;
    endtask

    task automatic step();
        bit exp_rdy, hpop, ppop, acc;
        @(negedge clk);
        if (inq.size() != 0 && (rmode != 1 || $urandom_range(3) != 0)) begin
            in_valid = 1; in_data = inq[0].d; in_sop = inq[0].sop; in_eop = inq[0].eop;
            in_error = inq[0].err; in_empty = inq[0].e; cfg = inq[0].cfg;
        end else begin
            in_valid = 0; in_data = {$urandom, $urandom}; in_sop = 1'($urandom);
            in_eop = 1'($urandom); in_error = 1'($urandom); in_empty = EW'($urandom); cfg = CW'($urandom);
        end
        hdr_ready = (rmode == 1) ? 1'($urandom) : (rmode == 2) ? 1'b0 : 1'b1;
        pay_ready = (rmode == 1) ? 1'($urandom) : 1'b1;
        #1;
        exp_rdy = (in_pkt && idx >= plen) ? (pq.size() < PD) : (hq.size() < HD);
        chk("in_ready", in_ready, exp_rdy);
        chk("hdr_valid", hdr_valid, hq.size() != 0);
        chk("pay_valid", pay_valid, pq.size() != 0);
        if (hq.size() != 0) begin
            chk("hdr_data", hdr_data, hq[0].d);
            chk("hdr_flags", {hdr_sop, hdr_eop, hdr_error, hdr_empty},
                {hq[0].sop, hq[0].eop, hq[0].err, hq[0].e});
        end
        if (pq.size() != 0) begin
            chk("pay_data", pay_data, pq[0].d);
            chk("pay_flags", {pay_sop, pay_eop, pay_error, pay_empty},
                {pq[0].sop, pq[0].eop, pq[0].err, pq[0].e});
            chk("pay_id", pay_id, pq[0].id);
        end
        chk("o_id", o_id, m_oid);
        chk("stat_pkts", stat_pkts, m_pkts);
        chk("stat_short", stat_short, m_short);
        chk("stat_drop", stat_drop, m_drop);
        hpop = hq.size() != 0 && hdr_ready;
        ppop = pq.size() != 0 && pay_ready;
        acc  = in_valid && exp_rdy;
        @(posedge clk);
        if (hpop) void'(hq.pop_front());
        if (ppop) begin
            if (pq[0].sop) m_oid = pq[0].id;
            void'(pq.pop_front());
        end
        if (acc) model_accept(inq.pop_front());
    endtask

    task automatic send_pkt(input int n, input logic [IDW-1:0] id, input int c, input bit first_sop);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.d = {$urandom, $urandom};
            if (i == 0) b.d[IDM -: IDW] = id;
            b.sop = (i == 0) && first_sop;
            b.eop = (i == n-1);
            b.err = ($urandom_range(7) == 0);
            b.e   = EW'($urandom);
            b.id  = '0;
            b.cfg = (i == 0) ? CW'(c) : CW'($urandom_range(15));
            inq.push_back(b);
        end
    endtask

    task automatic run(input int max);
        int n = 0;
        while ((inq.size() + hq.size() + pq.size()) != 0 && n < max) begin step(); n++; end
        chk("drained", inq.size() + hq.size() + pq.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk); reset = 1; in_valid = 0;
        @(negedge clk); reset = 0;
        inq.delete(); hq.delete(); pq.delete();
        in_pkt = 0; idx = 0; plen = 1; m_oid = '0; m_pkts = 0; m_short = 0; m_drop = 0;
        #1;
        chk("rst_hdr_valid", hdr_valid, 0);
        chk("rst_pay_valid", pay_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_o_id", o_id, 0);
        chk("rst_stats", {stat_pkts, stat_short, stat_drop}, 0);
    endtask

    initial begin
        int guard;
        rmode = 0;
        do_reset();
        // L=3, six beats, fixed ID
        send_pkt(6, 32'h12345678, 3, 1);
        run(100);
        chk("t1_pkts", stat_pkts, 1);
        chk("t1_o_id", o_id, 32'h12345678);
        // short packet, then a normal one
        send_pkt(2, 32'hA5A5_0001, 4, 1);
        run(100);
        chk("t2_short", stat_short, 1);
        send_pkt(7, 32'hA5A5_0002, 4, 1);
        run(100);
        // length clamping
        send_pkt(3, 32'h0000_00C0, 0, 1);
        send_pkt(13, 32'h0000_00CF, 15, 1);
        run(200);
        // stray beats in IDLE
        for (int i = 0; i < 3; i++) send_pkt(1, 32'h0, 3, 0);
        send_pkt(5, 32'hD0D0_D0D0, 2, 1);
        run(100);
        chk("t4_drop", stat_drop, 3);
        // header backpressure
        rmode = 2;
        send_pkt(12, 32'hBEEF_0008, 8, 1);
        for (int i = 0; i < 10; i++) step();
        @(negedge clk); #1;
        chk("stall_in_ready", in_ready, 0);
        chk("stall_hdr_cnt", hq.size(), HD);
        rmode = 0;
        run(200);
        // reset during payload of packet A, then packet B
        send_pkt(10, 32'hAAAA_AAAA, 2, 1);
        guard = 0;
        while (!(in_pkt && idx > plen) && guard < 50) begin step(); guard++; end
        chk("reached_pay", in_pkt && idx > plen, 1);
        do_reset();
        send_pkt(6, 32'hBBBB_BBBB, 3, 1);
        run(100);
        chk("b_pkts", stat_pkts, 1);
        chk("b_o_id", o_id, 32'hBBBB_BBBB);
        // random traffic with random backpressure
        rmode = 1;
        for (int p = 0; p < 30; p++) begin
            if ($urandom_range(5) == 0) send_pkt(1, 32'h0, 3, 0);
            send_pkt($urandom_range(1, 14), $urandom, $urandom_range(0, 15), 1);
        end
        run(5000);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
